// File: rtl/lectura_contadores.sv
// -----------------------------------------------------------------------------
// lectura_contadores
//
// Readout sequencer for the four per-output-FIFO word counters. A start pulse,
// accepted only while the main FSM reports idle, walks req/idx through
// counters 0..3. Each count is captured when the counter block answers with
// cnt_valid. The captured counts are summed into total. The sequence ends with
// a one-cycle done pulse. If a counter does not answer for TIMEOUT consecutive
// cycles, the sequence aborts, raises the sticky error flag and pulses done.
//
// Ports
//   clk        in   1        clock, all logic on posedge
//   rst_l      in   1        asynchronous active-low reset
//   start      in   1        readout request, single-cycle pulse
//   idle       in   1        main FSM idle flag, gates start acceptance
//   cnt_data   in   CNT_W    count returned by the counter block
//   cnt_valid  in   1        cnt_data valid this cycle
//   req        out  1        read request to the counter block
//   idx        out  2        counter index being read
//   busy       out  1        sequence in progress
//   done       out  1        one-cycle pulse, sequence finished (ok or error)
//   error      out  1        sticky, last sequence aborted by timeout
//   cuenta_0..cuenta_3 out CNT_W  captured counts, held until the next start
//   total      out  CNT_W+2  sum of the captured counts
// -----------------------------------------------------------------------------
module lectura_contadores #(
    parameter int CNT_W   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               start,
    input  logic               idle,
    input  logic [CNT_W-1:0]   cnt_data,
    input  logic               cnt_valid,
    output logic               req,
    output logic [1:0]         idx,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [CNT_W-1:0]   cuenta_0,
    output logic [CNT_W-1:0]   cuenta_1,
    output logic [CNT_W-1:0]   cuenta_2,
    output logic [CNT_W-1:0]   cuenta_3,
    output logic [CNT_W+1:0]   total
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);
    localparam logic [7:0] WAIT_MAX_C = 8'hFF;

    state_t             state_r;
    state_t             state_s;

    logic [1:0]         idx_r;
    logic [7:0]         wait_r;
    logic [CNT_W-1:0]   cuenta_0_r;
    logic [CNT_W-1:0]   cuenta_1_r;
    logic [CNT_W-1:0]   cuenta_2_r;
    logic [CNT_W-1:0]   cuenta_3_r;
    logic [CNT_W+1:0]   total_r;
    logic               error_r;
    logic               req_r;
    logic               busy_r;
    logic               done_r;

    logic               accept_s;
    logic               capture_s;
    logic               timeout_s;
    logic [7:0]         wait_inc_s;
    logic [CNT_W+1:0]   cnt_ext_s;

    // Saturating wait-counter increment and zero-extended count for the adder.
    always_comb begin
        wait_inc_s = wait_r;
        if (wait_r == WAIT_MAX_C) begin
            wait_inc_s = WAIT_MAX_C;
        end else begin
            wait_inc_s = wait_r + 8'd1;
        end
        cnt_ext_s = {2'b00, cnt_data};
    end

    // Next-state logic; a capture in the cycle that would expire the wait
    // counter takes precedence over the timeout.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && idle) begin
                    accept_s = 1'b1;
                    state_s  = ST_REQ;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (cnt_valid) begin
                    capture_s = 1'b1;
                    if (idx_r == 2'd3) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else if (wait_inc_s >= TIMEOUT_C) begin
                    timeout_s = 1'b1;
                    state_s   = ST_ERR;
                end else begin
                    state_s   = ST_REQ;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            ST_ERR: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Index, wait counter, captured counts, total and sticky error.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            idx_r      <= 2'd0;
            wait_r     <= 8'd0;
            cuenta_0_r <= '0;
            cuenta_1_r <= '0;
            cuenta_2_r <= '0;
            cuenta_3_r <= '0;
            total_r    <= '0;
            error_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        idx_r      <= 2'd0;
                        wait_r     <= 8'd0;
                        cuenta_0_r <= '0;
                        cuenta_1_r <= '0;
                        cuenta_2_r <= '0;
                        cuenta_3_r <= '0;
                        total_r    <= '0;
                        error_r    <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (capture_s) begin
                        case (idx_r)
                            2'd0:    cuenta_0_r <= cnt_data;
                            2'd1:    cuenta_1_r <= cnt_data;
                            2'd2:    cuenta_2_r <= cnt_data;
                            2'd3:    cuenta_3_r <= cnt_data;
                            default: cuenta_0_r <= cuenta_0_r;
                        endcase
                        total_r <= total_r + cnt_ext_s;
                        wait_r  <= 8'd0;
                        if (idx_r == 2'd3) begin
                            idx_r <= 2'd0;
                        end else begin
                            idx_r <= idx_r + 2'd1;
                        end
                    end else begin
                        wait_r <= wait_inc_s;
                        if (timeout_s) begin
                            error_r <= 1'b1;
                            idx_r   <= 2'd0;
                        end
                    end
                end
                ST_DONE: begin
                    idx_r <= 2'd0;
                end
                ST_ERR: begin
                    idx_r <= 2'd0;
                end
                default: begin
                    idx_r <= 2'd0;
                end
            endcase
        end
    end

    // Handshake flags registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            req_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            req_r  <= (state_s == ST_REQ);
            busy_r <= (state_s == ST_REQ);
            done_r <= (state_s == ST_DONE) || (state_s == ST_ERR);
        end
    end

    assign req      = req_r;
    assign idx      = idx_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign error    = error_r;
    assign cuenta_0 = cuenta_0_r;
    assign cuenta_1 = cuenta_1_r;
    assign cuenta_2 = cuenta_2_r;
    assign cuenta_3 = cuenta_3_r;
    assign total    = total_r;

endmodule

// File: tb/tb_lectura_contadores.sv
// -----------------------------------------------------------------------------
// tb_lectura_contadores
//
// Bench for the counter readout sequencer. A small counter-block model answers
// req with cnt_valid = req & idle and cnt_data = the selected count. Each
// scenario derives its expected per-cycle handshake and final counts from the
// per-counter stall lengths, using the readout rules directly.
// -----------------------------------------------------------------------------
module tb_lectura_contadores;

    localparam int CNT_W   = 5;
    localparam int TIMEOUT = 15;

    logic             clk;
    logic             rst_l;
    logic             start;
    logic             idle;
    logic [CNT_W-1:0] cnt_data;
    logic             cnt_valid;
    logic             req;
    logic [1:0]       idx;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] cuenta_0;
    logic [CNT_W-1:0] cuenta_1;
    logic [CNT_W-1:0] cuenta_2;
    logic [CNT_W-1:0] cuenta_3;
    logic [CNT_W+1:0] total;

    logic [CNT_W-1:0] counts_r [4];

    int pass_cnt;
    int total_cnt;

    lectura_contadores #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .start     (start),
        .idle      (idle),
        .cnt_data  (cnt_data),
        .cnt_valid (cnt_valid),
        .req       (req),
        .idx       (idx),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cuenta_0  (cuenta_0),
        .cuenta_1  (cuenta_1),
        .cuenta_2  (cuenta_2),
        .cuenta_3  (cuenta_3),
        .total     (total)
    );

    // Counter block: answers only while the main FSM is idle.
    assign cnt_valid = req & idle;
    assign cnt_data  = counts_r[idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one sequence. stl[i] is the number of cycles idle is held low
    // while counter i is requested; TIMEOUT or more stalls abort the readout.
    task automatic run_seq(input string name,
                           input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1,
                           input logic [CNT_W-1:0] c2, input logic [CNT_W-1:0] c3,
                           input int s0, input int s1, input int s2, input int s3,
                           input bit inject_start);
        logic [5:0]       expv [128];
        bit               pat  [128];
        logic [CNT_W-1:0] cv   [4];
        int               stl  [4];
        logic [CNT_W-1:0] ecu  [4];
        logic [CNT_W+1:0] etot;
        logic [5:0]       obs;
        int               cyc;
        int               w;
        int               done_c;
        bit               err;

        cv[0] = c0; cv[1] = c1; cv[2] = c2; cv[3] = c3;
        stl[0] = s0; stl[1] = s1; stl[2] = s2; stl[3] = s3;
        for (int i = 0; i < 128; i++) begin
            pat[i]  = 1'b1;
            expv[i] = 6'd0;
        end
        for (int i = 0; i < 4; i++) begin
            ecu[i] = '0;
        end
        etot = '0;
        err  = 1'b0;
        cyc  = 1;
        // Expected trace: {req, idx, busy, done, error} per cycle after accept.
        for (int i = 0; i < 4; i++) begin
            if (!err) begin
                w = 0;
                for (int s = 0; s < stl[i] && !err; s++) begin
                    expv[cyc] = {1'b1, 2'(i), 1'b1, 1'b0, 1'b0};
                    pat[cyc]  = 1'b0;
                    cyc++;
                    w++;
                    if (w >= TIMEOUT) begin
                        err = 1'b1;
                    end
                end
                if (!err) begin
                    expv[cyc] = {1'b1, 2'(i), 1'b1, 1'b0, 1'b0};
                    pat[cyc]  = 1'b1;
                    cyc++;
                    ecu[i] = cv[i];
                    etot   = etot + (CNT_W+2)'(cv[i]);
                end
            end
        end
        done_c = cyc;
        expv[done_c] = {1'b0, 2'b00, 1'b0, 1'b1, err};
        for (int j = 1; j <= 3; j++) begin
            expv[done_c + j] = {5'b00000, err};
        end

        for (int i = 0; i < 4; i++) begin
            counts_r[i] = cv[i];
        end
        @(negedge clk);
        start = 1'b1;
        idle  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        idle  = pat[1];
        for (int c = 1; c <= done_c + 3; c++) begin
            @(negedge clk);
            obs = {req, idx, busy, done, error};
            total_cnt++;
            if (obs !== expv[c]) begin
                $display("FAIL %s cycle %0d {req,idx,busy,done,error}: got %b expected %b",
                         name, c, obs, expv[c]);
            end else begin
                pass_cnt++;
            end
            if (c == 1) begin
                total_cnt++;
                if ({cuenta_0, cuenta_1, cuenta_2, cuenta_3, total} !== '0) begin
                    $display("FAIL %s cleared_on_start: got %h/%h/%h/%h total %0d expected all 0",
                             name, cuenta_0, cuenta_1, cuenta_2, cuenta_3, total);
                end else begin
                    pass_cnt++;
                end
            end
            @(posedge clk);
            #1;
            idle  = pat[c + 1];
            start = inject_start && ((c + 1 == 2) || (c + 1 == 5));
        end
        start = 1'b0;
        idle  = 1'b1;
        total_cnt++;
        if ({cuenta_0, cuenta_1, cuenta_2, cuenta_3, total} !==
            {ecu[0], ecu[1], ecu[2], ecu[3], etot}) begin
            $display("FAIL %s results: got %0d,%0d,%0d,%0d total %0d expected %0d,%0d,%0d,%0d total %0d",
                     name, cuenta_0, cuenta_1, cuenta_2, cuenta_3, total,
                     ecu[0], ecu[1], ecu[2], ecu[3], etot);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        start = 1'b0;
        idle  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            counts_r[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({req, idx, busy, done, error, cuenta_0, cuenta_1, cuenta_2, cuenta_3, total} !== '0) begin
            $display("FAIL reset_state: got req=%b idx=%0d busy=%b done=%b error=%b total=%0d expected all 0",
                     req, idx, busy, done, error, total);
        end else begin
            pass_cnt++;
        end
        rst_l = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nominal();
        run_seq("nominal", 5'd3, 5'd0, 5'd31, 5'd7, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_stall();
        run_seq("stall_idx2", 5'd3, 5'd0, 5'd31, 5'd7, 0, 0, 5, 0, 1'b0);
    endtask

    task automatic test_timeout();
        run_seq("timeout", 5'd9, 5'd4, 5'd5, 5'd6, 0, 40, 0, 0, 1'b0);
    endtask

    task automatic test_all_max();
        run_seq("all_max", 5'd31, 5'd31, 5'd31, 5'd31, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_boundary();
        run_seq("capture_wins", 5'd1, 5'd2, 5'd17, 5'd8, 0, 0, TIMEOUT - 1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_seq("ignored_start", 5'd12, 5'd30, 5'd1, 5'd19, 0, 0, 0, 0, 1'b1);
    endtask

    task automatic test_idle_start();
        @(negedge clk);
        start = 1'b1;
        idle  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        idle  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({req, busy, done} !== 3'b000) begin
                $display("FAIL start_while_not_idle cycle %0d: got req=%b busy=%b done=%b expected 0",
                         c, req, busy, done);
            end else begin
                pass_cnt++;
            end
        end
    endtask

    task automatic test_async_reset();
        counts_r[0] = 5'd3; counts_r[1] = 5'd0; counts_r[2] = 5'd31; counts_r[3] = 5'd7;
        @(negedge clk);
        start = 1'b1;
        idle  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_l = 1'b0;
        #1;
        total_cnt++;
        if ({req, idx, busy, done, error, cuenta_0, cuenta_1, cuenta_2, cuenta_3, total} !== '0) begin
            $display("FAIL async_reset: got req=%b idx=%0d busy=%b cuenta_0=%0d total=%0d expected all 0",
                     req, idx, busy, cuenta_0, total);
        end else begin
            pass_cnt++;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({req, busy, done} !== 3'b000) begin
                $display("FAIL reset_no_done: got req=%b busy=%b done=%b expected 0", req, busy, done);
            end else begin
                pass_cnt++;
            end
        end
        rst_l = 1'b1;
        run_seq("after_reset", 5'd3, 5'd0, 5'd31, 5'd7, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        int s [4];
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 4; i++) begin
                s[i] = int'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 3) == 0) begin
                s[$urandom_range(0, 3)] = int'($urandom_range(TIMEOUT - 2, TIMEOUT + 4));
            end
            run_seq("random",
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    s[0], s[1], s[2], s[3], 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_l     = 1'b0;
        start     = 1'b0;
        idle      = 1'b1;
        test_reset();
        test_nominal();
        test_stall();
        test_timeout();
        test_all_max();
        test_boundary();
        test_back_to_back();
        test_idle_start();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
